// File: rtl/decode_stage_pipe_if.sv
// ============================================================================
//  Module   : decode_stage_pipe_if
//  Brief    : Fetch/execute/write-back bundle for the RV32-style decode stage.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface decode_stage_pipe_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
);
   localparam int AW = $clog2(NREGS);

   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   logic [31:0]     in_instr;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_rs1_data;
   logic [XLEN-1:0] out_rs2_data;
   logic [XLEN-1:0] out_imm;
   logic [AW-1:0]   out_rd;
   logic [AW-1:0]   out_rs1;
   logic [AW-1:0]   out_rs2;
   logic [2:0]      out_funct3;
   logic [6:0]      out_funct7;
   logic [11:0]     out_ctl;
   logic            out_illegal;
   logic            wb_en;
   logic [AW-1:0]   wb_addr;
   logic [XLEN-1:0] wb_data;

   modport master (
      output flush, in_valid, in_pc, in_instr, out_ready, wb_en, wb_addr, wb_data,
      input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
             out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_ctl, out_illegal
   );

   modport slave (
      input  flush, in_valid, in_pc, in_instr, out_ready, wb_en, wb_addr, wb_data,
      output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
             out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_ctl, out_illegal
   );
endinterface

`default_nettype wire

// File: rtl/decode_stage_pipe.sv
// ============================================================================
//  Module   : decode_stage_pipe
//  Brief    : RV32-style decode with register file, immediate generation and a
//             valid/ready ID/EX register. Define DECODE_LOADUSE_EN to enable
//             the internal load-use interlock.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module decode_stage_pipe #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic               clk,
   input  logic               reset,
   decode_stage_pipe_if.slave bus
);
   localparam int AW = $clog2(NREGS);

   localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
   localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
   localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
   localparam logic [6:0] c_OPC_OP     = 7'b0110011;
   localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
   localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;

   // ctl: {auipc, lui, jalr, jal, alu_op[1:0], branch, mem_write, mem_read, reg_write, mem_to_reg, alu_src}
   localparam logic [11:0] c_CTL_LOAD   = 12'h00F;
   localparam logic [11:0] c_CTL_OPIMM  = 12'h085;
   localparam logic [11:0] c_CTL_JALR   = 12'h205;
   localparam logic [11:0] c_CTL_STORE  = 12'h011;
   localparam logic [11:0] c_CTL_BRANCH = 12'h060;
   localparam logic [11:0] c_CTL_JAL    = 12'h104;
   localparam logic [11:0] c_CTL_OP     = 12'h084;
   localparam logic [11:0] c_CTL_LUI    = 12'h405;
   localparam logic [11:0] c_CTL_AUIPC  = 12'h805;

   logic [31:0]     w_instr;
   logic [6:0]      w_opcode;
   logic [AW-1:0]   w_rs1_idx;
   logic [AW-1:0]   w_rs2_idx;
   logic [11:0]     w_ctl;
   logic            w_illegal;
   logic [31:0]     w_imm32;
   logic [XLEN-1:0] w_imm;
   logic [XLEN-1:0] w_rs1_data;
   logic [XLEN-1:0] w_rs2_data;
   logic            w_hazard;
   logic            w_in_ready;
   logic            w_in_fire;
   logic            w_out_fire;
   logic            w_wb_we;

   logic [XLEN-1:0] rf_q [NREGS];

   logic            valid_q,   valid_d;
   logic [XLEN-1:0] pc_q,      pc_d;
   logic [XLEN-1:0] rs1_data_q, rs1_data_d;
   logic [XLEN-1:0] rs2_data_q, rs2_data_d;
   logic [XLEN-1:0] imm_q,     imm_d;
   logic [AW-1:0]   rd_q,      rd_d;
   logic [AW-1:0]   rs1_q,     rs1_d;
   logic [AW-1:0]   rs2_q,     rs2_d;
   logic [2:0]      funct3_q,  funct3_d;
   logic [6:0]      funct7_q,  funct7_d;
   logic [11:0]     ctl_q,     ctl_d;
   logic            illegal_q, illegal_d;

   assign w_instr   = bus.in_instr;
   assign w_opcode  = w_instr[6:0];
   assign w_rs1_idx = w_instr[15 +: AW];
   assign w_rs2_idx = w_instr[20 +: AW];
   assign w_wb_we   = bus.wb_en && (bus.wb_addr != '0);

   always_comb begin
      w_ctl     = '0;
      w_illegal = 1'b0;
      w_imm32   = '0;
      case (w_opcode)
         c_OPC_LOAD: begin
            w_ctl   = c_CTL_LOAD;
            w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
         end
         c_OPC_OPIMM: begin
            w_ctl   = c_CTL_OPIMM;
            w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
         end
         c_OPC_JALR: begin
            w_ctl   = c_CTL_JALR;
            w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
         end
         c_OPC_STORE: begin
            w_ctl   = c_CTL_STORE;
            w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
         end
         c_OPC_BRANCH: begin
            w_ctl   = c_CTL_BRANCH;
            w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                       w_instr[30:25], w_instr[11:8], 1'b0};
         end
         c_OPC_JAL: begin
            w_ctl   = c_CTL_JAL;
            w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                       w_instr[20], w_instr[30:21], 1'b0};
         end
         c_OPC_OP: begin
            w_ctl   = c_CTL_OP;
         end
         c_OPC_LUI: begin
            w_ctl   = c_CTL_LUI;
            w_imm32 = {w_instr[31:12], 12'b0};
         end
         c_OPC_AUIPC: begin
            w_ctl   = c_CTL_AUIPC;
            w_imm32 = {w_instr[31:12], 12'b0};
         end
         default: begin
            w_illegal = 1'b1;
         end
      endcase
   end

   generate
      if (XLEN > 32) begin : g_imm_wide
         assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
      end else begin : g_imm_native
         assign w_imm = w_imm32[XLEN-1:0];
      end
   endgenerate

   // Same-edge write-back is forwarded; x0 never forwards and always reads 0.
   always_comb begin
      w_rs1_data = '0;
      if (w_rs1_idx != '0) begin
         if (w_wb_we && (bus.wb_addr == w_rs1_idx)) w_rs1_data = bus.wb_data;
         else                                      w_rs1_data = rf_q[w_rs1_idx];
      end
   end

   always_comb begin
      w_rs2_data = '0;
      if (w_rs2_idx != '0) begin
         if (w_wb_we && (bus.wb_addr == w_rs2_idx)) w_rs2_data = bus.wb_data;
         else                                      w_rs2_data = rf_q[w_rs2_idx];
      end
   end

`ifdef DECODE_LOADUSE_EN
   logic w_uses_rs1;
   logic w_uses_rs2;

   always_comb begin
      w_uses_rs1 = 1'b0;
      w_uses_rs2 = 1'b0;
      case (w_opcode)
         c_OPC_LOAD, c_OPC_OPIMM, c_OPC_JALR: w_uses_rs1 = 1'b1;
         c_OPC_STORE, c_OPC_BRANCH, c_OPC_OP: begin
            w_uses_rs1 = 1'b1;
            w_uses_rs2 = 1'b1;
         end
         default: ;
      endcase
   end

   // Keyed on the load flag (mem_read) of the instruction held in ID/EX.
   assign w_hazard = bus.in_valid && valid_q && ctl_q[3] && (rd_q != '0) &&
                     ((w_uses_rs1 && (w_rs1_idx == rd_q)) ||
                      (w_uses_rs2 && (w_rs2_idx == rd_q)));
`else
   assign w_hazard = 1'b0;
`endif

   assign w_in_ready = bus.flush || ((!valid_q || bus.out_ready) && !w_hazard);
   assign w_in_fire  = bus.in_valid && w_in_ready;
   assign w_out_fire = valid_q && bus.out_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else if (w_wb_we) begin
         rf_q[bus.wb_addr] <= bus.wb_data;
      end
   end

   always_comb begin
      valid_d    = valid_q;
      pc_d       = pc_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      rd_d       = rd_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      funct3_d   = funct3_q;
      funct7_d   = funct7_q;
      ctl_d      = ctl_q;
      illegal_d  = illegal_q;
      if (bus.flush) begin
         valid_d = 1'b0;
      end else if (w_in_fire) begin
         valid_d    = 1'b1;
         pc_d       = bus.in_pc;
         rs1_data_d = w_rs1_data;
         rs2_data_d = w_rs2_data;
         imm_d      = w_imm;
         rd_d       = w_instr[7 +: AW];
         rs1_d      = w_rs1_idx;
         rs2_d      = w_rs2_idx;
         funct3_d   = w_instr[14:12];
         funct7_d   = w_instr[31:25];
         ctl_d      = w_ctl;
         illegal_d  = w_illegal;
      end else if (w_out_fire) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         rd_q       <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         funct3_q   <= '0;
         funct7_q   <= '0;
         ctl_q      <= '0;
         illegal_q  <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         rd_q       <= rd_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         funct3_q   <= funct3_d;
         funct7_q   <= funct7_d;
         ctl_q      <= ctl_d;
         illegal_q  <= illegal_d;
      end
   end

   assign bus.in_ready     = w_in_ready;
   assign bus.out_valid    = valid_q;
   assign bus.out_pc       = pc_q;
   assign bus.out_rs1_data = rs1_data_q;
   assign bus.out_rs2_data = rs2_data_q;
   assign bus.out_imm      = imm_q;
   assign bus.out_rd       = rd_q;
   assign bus.out_rs1      = rs1_q;
   assign bus.out_rs2      = rs2_q;
   assign bus.out_funct3   = funct3_q;
   assign bus.out_funct7   = funct7_q;
   assign bus.out_ctl      = ctl_q;
   assign bus.out_illegal  = illegal_q;

endmodule

`default_nettype wire
